data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory for a multi-cycle CPU.
// One request in flight; IDLE -> WAIT -> RESP handshake with error strobe.
module data_mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        mem_ready,
  output logic        busy,
  output logic        mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;

  logic          r_wr;
  logic          r_both;
  logic          r_mis;
  logic [AW-1:0] r_idx;
  logic [31:0]   r_din;

  logic [31:0]   r_dout;
  logic          r_err;

  logic [31:0]   r_mem [DEPTH];

  logic          w_req;
  logic          w_accept;
  logic          w_to_resp;
  logic [AW-1:0] w_in_idx;

  logic          w_wr;
  logic          w_both;
  logic          w_mis;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_din;
  logic          w_commit;

  assign w_req    = mem_read | mem_write;
  assign w_in_idx = AW'(addr[31:2] % 30'(DEPTH));

  // next state and wait counter
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    w_to_resp = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next    = RESP;
            w_to_resp = 1'b1;
            w_cnt_nxt = 4'd0;
          end else begin
            w_next    = WAIT;
            w_cnt_nxt = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next    = RESP;
          w_to_resp = 1'b1;
          w_cnt_nxt = 4'd0;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_next = IDLE;
      end
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  // operation fields: live inputs when a LATENCY=1 request
  // enters RESP on its accepting edge, latched copy otherwise
  always_comb begin
    w_wr   = r_wr;
    w_both = r_both;
    w_mis  = r_mis;
    w_idx  = r_idx;
    w_din  = r_din;
    if (w_accept) begin
      w_wr   = mem_write;
      w_both = mem_read & mem_write;
      w_mis  = |addr[1:0];
      w_idx  = w_in_idx;
      w_din  = din;
    end
    w_commit = reset & w_to_resp & w_wr & ~w_mis;
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // capture the request so later input changes cannot disturb it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr   <= 1'b0;
      r_both <= 1'b0;
      r_mis  <= 1'b0;
      r_idx  <= '0;
      r_din  <= 32'd0;
    end else if (w_accept) begin
      r_wr   <= mem_write;
      r_both <= mem_read & mem_write;
      r_mis  <= |addr[1:0];
      r_idx  <= w_in_idx;
      r_din  <= din;
    end
  end

  // response data and error flag, loaded on the edge entering RESP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout <= 32'd0;
      r_err  <= 1'b0;
    end else if (w_to_resp) begin
      r_err <= w_mis | w_both;
      if (w_mis) begin
        r_dout <= 32'd0;
      end else if (!w_wr) begin
        r_dout <= r_mem[w_idx];
      end
    end
  end

  // storage: no reset so contents survive it
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[w_idx] <= w_din;
    end
  end

  assign dout      = r_dout;
  assign mem_ready = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign mem_err   = (r_state == RESP) & r_err;

endmodule
